// File: rtl/non_restoring_divider_seq.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock through a
// shared add/subtract path, with a start/busy/done handshake and a divide-by-zero fast path.
module non_restoring_divider_seq #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]              state;
  logic signed [WIDTH:0]   acc;
  logic [WIDTH-1:0]        qs;
  logic [WIDTH-1:0]        div;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH:0]   div_ext;
  logic signed [WIDTH:0]   acc_next;
  logic signed [WIDTH:0]   acc_fix;

  // The shift drops the old sign bit; the result is still exact because the true
  // partial remainder always lies in [-D, D) and so fits WIDTH+1 bits after wrapping.
  function automatic logic signed [WIDTH:0] nr_step(input logic signed [WIDTH:0] a,
                                                   input logic                  msb,
                                                   input logic signed [WIDTH:0] d);
    logic signed [WIDTH:0] sh;
    sh = {a[WIDTH-1:0], msb};
    return a[WIDTH] ? (sh + d) : (sh - d);
  endfunction

  function automatic logic signed [WIDTH:0] fix_rem(input logic signed [WIDTH:0] a,
                                                   input logic signed [WIDTH:0] d);
    return a[WIDTH] ? (a + d) : a;
  endfunction

  assign div_ext  = {1'b0, div};
  assign acc_next = nr_step(acc, qs[WIDTH-1], div_ext);
  assign acc_fix  = fix_rem(acc, div_ext);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      qs    <= '0;
      div   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (Y != '0) begin
              acc   <= '0;
              qs    <= X;
              div   <= Y;
              cnt   <= '0;
              state <= ST_ITER;
            end else begin
              Q    <= '1;
              R    <= X;
              dbz  <= 1'b1;
              done <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          acc <= acc_next;
          qs  <= {qs[WIDTH-2:0], ~acc_next[WIDTH]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          acc   <= acc_fix;
          Q     <= qs;
          R     <= acc_fix[WIDTH-1:0];
          dbz   <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_non_restoring_divider_seq.sv
// Directed bench for non_restoring_divider_seq at WIDTH=4 and WIDTH=8, with a
// randomised WIDTH=8 sweep against X/Y and X%Y.
module tb_non_restoring_divider_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s4, b4, d4, z4;
  logic [3:0] x4, y4, q4, r4;
  logic       s8, b8, d8, z8;
  logic [7:0] x8, y8, q8, r8;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  non_restoring_divider_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(s4), .X(x4), .Y(y4),
    .busy(b4), .done(d4), .Q(q4), .R(r4), .dbz(z4)
  );

  non_restoring_divider_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .X(x8), .Y(y8),
    .busy(b8), .done(d8), .Q(q8), .R(r8), .dbz(z8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One division on the chosen instance; checks latency, busy span and result.
  task automatic run(input bit w8, input int x, input int y, input int eq, input int er,
                     input int ez, input int elat, input string tag);
    int lat, nb;
    logic dn, bs;
    if (w8) begin s8 = 1'b1; x8 = x[7:0]; y8 = y[7:0]; end
    else    begin s4 = 1'b1; x4 = x[3:0]; y4 = y[3:0]; end
    tick();
    s4 = 1'b0; s8 = 1'b0;
    lat = 0; nb = 0;
    dn = w8 ? d8 : d4;
    while (!dn && lat < 40) begin
      bs = w8 ? b8 : b4;
      if (bs) nb++;
      tick();
      lat++;
      dn = w8 ? d8 : d4;
    end
    chk({tag, ".done"}, 32'(dn), 32'd1);
    chk({tag, ".lat"},  32'(lat), 32'(elat));
    chk({tag, ".busy_cycles"}, 32'(nb), 32'(elat));
    chk({tag, ".busy_at_done"}, 32'(w8 ? b8 : b4), 32'd0);
    chk({tag, ".Q"},   w8 ? 32'(q8) : 32'(q4), 32'(eq));
    chk({tag, ".R"},   w8 ? 32'(r8) : 32'(r4), 32'(er));
    chk({tag, ".dbz"}, w8 ? 32'(z8) : 32'(z4), 32'(ez));
  endtask

  initial begin
    int t1, t2, nd, lat, rx, ry;
    rst = 1'b1; s4 = 1'b0; s8 = 1'b0; x4 = '0; y4 = '0; x8 = '0; y8 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.busy4", 32'(b4), 32'd0);
    chk("rst.done4", 32'(d4), 32'd0);
    chk("rst.Q4", 32'(q4), 32'd0);
    chk("rst.R4", 32'(r4), 32'd0);
    chk("rst.dbz4", 32'(z4), 32'd0);
    chk("rst.Q8", 32'(q8), 32'd0);

    // Directed WIDTH=4 cases, including the X<Y, X=0, Y=1 and X=Y boundaries
    run(0, 6, 2, 3, 0, 0, 5, "d6_2");
    run(0, 12, 3, 4, 0, 0, 5, "d12_3");
    run(0, 13, 12, 1, 1, 0, 5, "d13_12");
    run(0, 5, 10, 0, 5, 0, 5, "d5_10");
    run(0, 9, 12, 0, 9, 0, 5, "d9_12");
    run(0, 14, 9, 1, 5, 0, 5, "d14_9");
    run(0, 0, 3, 0, 0, 0, 5, "d0_3");
    run(0, 11, 1, 11, 0, 0, 5, "d11_1");
    run(0, 7, 7, 1, 0, 0, 5, "d7_7");
    run(0, 15, 15, 1, 0, 0, 5, "d15_15");

    // Divide by zero completes on the very next cycle without going busy
    run(0, 7, 0, 15, 7, 1, 0, "dbz7");
    run(0, 8, 3, 2, 2, 0, 5, "d8_3");

    // Inputs thrash while busy; the result must come from the captured operands
    s4 = 1'b1; x4 = 4'd15; y4 = 4'd4;
    tick();
    lat = 0; nd = 0;
    while (!d4 && lat < 40) begin
      chk("hold.Q", 32'(q4), 32'd2);
      chk("hold.R", 32'(r4), 32'd2);
      s4 = ~s4; x4 = 4'($urandom); y4 = 4'($urandom);
      tick();
      lat++;
    end
    s4 = 1'b0;
    chk("thrash.lat", 32'(lat), 32'd5);
    chk("thrash.Q", 32'(q4), 32'd3);
    chk("thrash.R", 32'(r4), 32'd3);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d4) nd++;
    end
    chk("thrash.extra_done", 32'(nd), 32'd0);

    // Reset mid-division aborts with no completion
    s4 = 1'b1; x4 = 4'd11; y4 = 4'd2;
    tick();
    s4 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", 32'(b4), 32'd0);
    chk("abort.done", 32'(d4), 32'd0);
    chk("abort.Q", 32'(q4), 32'd0);
    chk("abort.R", 32'(r4), 32'd0);
    chk("abort.dbz", 32'(z4), 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (d4) nd++;
    end
    chk("abort.no_done", 32'(nd), 32'd0);
    run(0, 11, 2, 5, 1, 0, 5, "d11_2");

    // Back-to-back: second start issued in the done cycle
    s4 = 1'b1; x4 = 4'd9; y4 = 4'd3;
    tick();
    s4 = 1'b0; lat = 0;
    while (!d4 && lat < 40) begin tick(); lat++; end
    t1 = cyc;
    chk("b2b1.done", 32'(d4), 32'd1);
    chk("b2b1.Q", 32'(q4), 32'd3);
    chk("b2b1.R", 32'(r4), 32'd0);
    s4 = 1'b1; x4 = 4'd10; y4 = 4'd4;
    tick();
    s4 = 1'b0;
    chk("b2b2.accepted", 32'(b4), 32'd1);
    lat = 0;
    while (!d4 && lat < 40) begin tick(); lat++; end
    t2 = cyc;
    chk("b2b2.done", 32'(d4), 32'd1);
    chk("b2b2.gap", 32'(t2 - t1), 32'd6);
    chk("b2b2.Q", 32'(q4), 32'd2);
    chk("b2b2.R", 32'(r4), 32'd2);

    // WIDTH=8
    run(1, 255, 7, 36, 3, 0, 9, "w8_255_7");
    run(1, 200, 1, 200, 0, 0, 9, "w8_200_1");
    run(1, 0, 255, 0, 0, 0, 9, "w8_0_255");
    run(1, 100, 0, 255, 100, 1, 0, "w8_dbz");
    for (int i = 0; i < 1000; i++) begin
      rx = int'($urandom_range(0, 255));
      ry = int'($urandom_range(1, 255));
      run(1, rx, ry, rx / ry, rx % ry, 0, 9, "w8_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
